accl_pair_sched: RTL and testbench

ACCL_PAIR_SCHED -- requirements
Module: accl_pair_sched

---
 rtl/accl_pair_sched.sv | 153 +++++++++++++++
 tb/tb_accl_pair_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accl_pair_sched.sv
// rtl/accl_pair_sched.sv - all-pairs (i,j) issue scheduler for a fixed-latency getAccl pipeline
// Each issued pair carries a tag that travels LATENCY cycles so the result can be identified.
module accl_pair_sched #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int LATENCY         = 123
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       hold_i,
    input  logic [BODY_ADDR_WIDTH:0]   num_bodies_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       issue_valid_o,
    output logic [BODY_ADDR_WIDTH-1:0] issue_i_o,
    output logic [BODY_ADDR_WIDTH-1:0] issue_j_o,
    output logic                       issue_self_o,
    output logic                       res_valid_o,
    output logic [BODY_ADDR_WIDTH-1:0] res_i_o,
    output logic [BODY_ADDR_WIDTH-1:0] res_j_o,
    output logic                       res_self_o,
    output logic                       res_last_j_o,
    output logic                       res_last_o
);
    localparam int W  = BODY_ADDR_WIDTH;
    localparam int TW = 2 * W + 4;
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [W:0] N_MAX = (W+1)'(BODIES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [W:0]     n_q, n_d;
    logic [W-1:0]   i_q, i_d, j_q, j_d;
    logic [CW-1:0]  infl_q, infl_d;
    logic           zdone_q, zdone_d;
    // tag layout: {valid, i, j, self, last_j, last}
    logic [TW-1:0]  tag_q, tag_d;
    logic [TW-1:0]  pipe_q [LATENCY];

    logic [W:0]     n_clamp;
    logic [W-1:0]   n_last;
    logic           last_j, last_i, n_one;

    always_comb begin
        n_clamp = (num_bodies_i > N_MAX) ? N_MAX : num_bodies_i;
        n_one   = (n_clamp == (W+1)'(1));
        n_last  = W'(n_q - (W+1)'(1));
        last_j  = (j_q == n_last);
        last_i  = (i_q == n_last);
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        zdone_d = 1'b0;
        tag_d   = '0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d = n_clamp;
                    if (n_clamp == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        // pair (0,0) goes straight into the issue register
                        tag_d = {1'b1, {W{1'b0}}, {W{1'b0}}, 1'b1, n_one, n_one};
                        i_d   = '0;
                        j_d   = n_one ? '0 : W'(1);
                        state_d = n_one ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!hold_i) begin
                    tag_d = {1'b1, i_q, j_q, (i_q == j_q), last_j, last_j && last_i};
                    if (last_j) begin
                        j_d = '0;
                        i_d = last_i ? '0 : i_q + W'(1);
                        if (last_i) state_d = S_DRAIN;
                    end else begin
                        j_d = j_q + W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (infl_q == '0) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (zdone_q) done_o = 1'b1;

        infl_d = infl_q + CW'(tag_d[TW-1]) - CW'(pipe_q[LATENCY-1][TW-1]);

        // abort wins over start and over drain completion
        if (abort_i) begin
            state_d = S_IDLE;
            tag_d   = '0;
            zdone_d = 1'b0;
            done_o  = 1'b0;
            infl_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            infl_q  <= '0;
            zdone_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            infl_q  <= infl_d;
            zdone_q <= zdone_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= tag_q;
            for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign issue_valid_o = tag_q[TW-1];
    assign issue_i_o     = tag_q[TW-2 -: W];
    assign issue_j_o     = tag_q[TW-2-W -: W];
    assign issue_self_o  = tag_q[2];
    assign res_valid_o   = pipe_q[LATENCY-1][TW-1];
    assign res_i_o       = pipe_q[LATENCY-1][TW-2 -: W];
    assign res_j_o       = pipe_q[LATENCY-1][TW-2-W -: W];
    assign res_self_o    = pipe_q[LATENCY-1][2];
    assign res_last_j_o  = pipe_q[LATENCY-1][1];
    assign res_last_o    = pipe_q[LATENCY-1][0];

endmodule

// File: tb/tb_accl_pair_sched.sv
// tb/tb_accl_pair_sched.sv - directed self-checking bench for accl_pair_sched
module tb_accl_pair_sched;
    localparam int BODIES = 8;
    localparam int AW     = 3;
    localparam int LAT    = 123;
    localparam int NONE   = 1 << 30;

    logic clk = 1'b0;
    logic rst, start, abort, hold;
    logic [AW:0] num_bodies;
    logic busy, done, issue_valid, issue_self, res_valid, res_self, res_last_j, res_last;
    logic [AW-1:0] issue_i, issue_j, res_i, res_j;

    typedef struct { int c; int i; int j; int s; int lj; int l; } ev_t;
    ev_t iss_q[$];
    ev_t res_q[$];
    int  done_q[$];
    int  checks = 0, errors = 0, ecnt = 0, bad_payload = 0, busy_cycles = 0;
    int  ks;

    accl_pair_sched #(.BODIES(BODIES), .BODY_ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .hold_i(hold),
        .num_bodies_i(num_bodies), .busy_o(busy), .done_o(done),
        .issue_valid_o(issue_valid), .issue_i_o(issue_i), .issue_j_o(issue_j),
        .issue_self_o(issue_self), .res_valid_o(res_valid), .res_i_o(res_i),
        .res_j_o(res_j), .res_self_o(res_self), .res_last_j_o(res_last_j),
        .res_last_o(res_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    // label = number of the rising edge that precedes this sample
    always @(negedge clk) begin
        if (issue_valid === 1'b1)
            iss_q.push_back('{ecnt, int'(issue_i), int'(issue_j), int'(issue_self), 0, 0});
        else if ({issue_i, issue_j, issue_self} !== '0) bad_payload++;
        if (res_valid === 1'b1)
            res_q.push_back('{ecnt, int'(res_i), int'(res_j), int'(res_self),
                              int'(res_last_j), int'(res_last)});
        else if ({res_i, res_j, res_self, res_last_j, res_last} !== '0) bad_payload++;
        if (done === 1'b1) done_q.push_back(ecnt);
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iss_q.delete();
        res_q.delete();
        done_q.delete();
        bad_payload = 0;
        busy_cycles = 0;
    endtask

    task automatic kick(input int n, output int k);
        num_bodies = AW'(0) + (AW+1)'(n);
        start = 1'b1;
        step(1);
        k = ecnt;
        start = 1'b0;
    endtask

    // first issue appears in the cycle right after the accepting edge ks
    task automatic check_sweep(input string nm, input int n, input int k, input int hidx, input int hlen);
        int np = n * n;
        int gap = (hidx < np) ? hlen : 0;
        int ec, ei, ej;
        checks++;
        if (iss_q.size() !== np) begin
            errors++; $display("FAIL %s issue_count got %0d want %0d", nm, iss_q.size(), np);
        end
        checks++;
        if (res_q.size() !== np) begin
            errors++; $display("FAIL %s res_count got %0d want %0d", nm, res_q.size(), np);
        end
        for (int m = 0; m < np; m++) begin
            ei = m / n; ej = m % n;
            ec = k + m + ((m >= hidx) ? hlen : 0);
            if (m < iss_q.size()) begin
                checks++;
                if (iss_q[m].c !== ec || iss_q[m].i !== ei || iss_q[m].j !== ej ||
                    iss_q[m].s !== int'(ei == ej)) begin
                    errors++;
                    $display("FAIL %s issue[%0d] got c=%0d (%0d,%0d) s=%0d want c=%0d (%0d,%0d) s=%0d",
                             nm, m, iss_q[m].c, iss_q[m].i, iss_q[m].j, iss_q[m].s, ec, ei, ej, int'(ei == ej));
                end
            end
            if (m < res_q.size()) begin
                checks++;
                if (res_q[m].c !== ec + LAT || res_q[m].i !== ei || res_q[m].j !== ej ||
                    res_q[m].s !== int'(ei == ej) || res_q[m].lj !== int'(ej == n - 1) ||
                    res_q[m].l !== int'(m == np - 1)) begin
                    errors++;
                    $display("FAIL %s res[%0d] got c=%0d (%0d,%0d) s=%0d lj=%0d l=%0d want c=%0d (%0d,%0d) s=%0d lj=%0d l=%0d",
                             nm, m, res_q[m].c, res_q[m].i, res_q[m].j, res_q[m].s, res_q[m].lj, res_q[m].l,
                             ec + LAT, ei, ej, int'(ei == ej), int'(ej == n - 1), int'(m == np - 1));
                end
            end
        end
        checks++;
        if (done_q.size() !== 1) begin
            errors++; $display("FAIL %s done_pulses got %0d want 1", nm, done_q.size());
        end else begin
            checks++;
            if (done_q[0] !== k + np - 1 + gap + LAT + 1) begin
                errors++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_q[0], k + np + gap + LAT);
            end
        end
        checks++;
        if (bad_payload !== 0) begin
            errors++; $display("FAIL %s idle_payload got %0d nonzero samples want 0", nm, bad_payload);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; num_bodies = '0;
        step(3);
        checks++;
        if ({busy, done, issue_valid, issue_i, issue_j, issue_self, res_valid, res_i, res_j,
             res_self, res_last_j, res_last} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b iv=%b rv=%b want all 0",
                               busy, done, issue_valid, res_valid);
        end
        rst = 1'b0;
        step(2);
        checks++;
        if ({busy, done, issue_valid, res_valid} !== 4'b0) begin
            errors++; $display("FAIL post_reset_idle got %b want 0000", {busy, done, issue_valid, res_valid});
        end
    endtask

    task automatic test_basic_n3();
        clr();
        kick(3, ks);
        step(9 + LAT + 6);
        check_sweep("n3", 3, ks, NONE, 0);
    endtask

    task automatic test_hold();
        clr();
        kick(4, ks);
        step(5);
        hold = 1'b1;
        step(5);
        hold = 1'b0;
        step(16 + 5 + LAT + 6);
        check_sweep("hold", 4, ks, 6, 5);
    endtask

    task automatic test_zero();
        clr();
        kick(0, ks);
        step(5);
        checks++;
        if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== ks)) begin
            errors++; $display("FAIL zero_done got %0d pulses want 1 at %0d", done_q.size(), ks);
        end
        checks++;
        if (busy_cycles !== 0 || iss_q.size() !== 0) begin
            errors++; $display("FAIL zero_busy got busy=%0d issues=%0d want 0/0", busy_cycles, iss_q.size());
        end
    endtask

    task automatic test_clamp();
        clr();
        kick(12, ks);
        step(64 + LAT + 6);
        check_sweep("clamp", 8, ks, NONE, 0);
    endtask

    task automatic test_abort_drain();
        clr();
        kick(8, ks);
        step(136);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got busy=%b res_valid=%b want 0/0", busy, res_valid);
        end
        step(LAT + 20);
        checks++;
        if (done_q.size() !== 0 || res_q.size() !== 14 || iss_q.size() !== 64) begin
            errors++; $display("FAIL abort_counts got done=%0d res=%0d iss=%0d want 0/14/64",
                               done_q.size(), res_q.size(), iss_q.size());
        end
        clr();
        kick(2, ks);
        step(4 + LAT + 6);
        check_sweep("after_abort", 2, ks, NONE, 0);
    endtask

    task automatic test_start_abort_same();
        clr();
        num_bodies = 4'd3;
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        step(5);
        checks++;
        if (busy_cycles !== 0 || iss_q.size() !== 0 || done_q.size() !== 0) begin
            errors++; $display("FAIL start_abort got busy=%0d iss=%0d done=%0d want 0/0/0",
                               busy_cycles, iss_q.size(), done_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        clr();
        kick(3, ks);
        num_bodies = 4'd5;
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6 + LAT + 6);
        check_sweep("busy_start", 3, ks, NONE, 0);
    endtask

    task automatic test_rst_mid();
        clr();
        kick(4, ks);
        step(4);
        rst = 1'b1;
        step(1);
        checks++;
        if ({busy, done, issue_valid, issue_i, issue_j, issue_self, res_valid, res_i, res_j,
             res_self, res_last_j, res_last} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got busy=%b iv=%b rv=%b want all 0", busy, issue_valid, res_valid);
        end
        rst = 1'b0;
        clr();
        step(LAT + 10);
        checks++;
        if (res_q.size() !== 0 || done_q.size() !== 0 || iss_q.size() !== 0) begin
            errors++; $display("FAIL rst_mid_residue got res=%0d done=%0d iss=%0d want 0/0/0",
                               res_q.size(), done_q.size(), iss_q.size());
        end
        clr();
        kick(1, ks);
        step(1 + LAT + 6);
        check_sweep("n1", 1, ks, NONE, 0);
    endtask

    initial begin
        test_reset();
        test_basic_n3();
        test_hold();
        test_zero();
        test_clamp();
        test_abort_drain();
        test_start_abort_same();
        test_start_while_busy();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
